// File: rtl/change_dispenser.sv
// Coin-return sequencer: pays out a refund greedily (1000/500/100/50 won),
// one coin per hopper handshake, with a sticky timeout fault.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic [6:0] Amount,
  input  logic       Ack,
  output logic       Return1000,
  output logic       Return500,
  output logic       Return100,
  output logic       Return50,
  output logic       Busy,
  output logic       Done,
  output logic       Fault,
  output logic [6:0] Remaining
);

  localparam logic [7:0] TMO = ACK_TIMEOUT[7:0];

  typedef enum logic [2:0] {IDLE, SELECT, REQ, RELEASE, FIN, FAULT} state_t;

  state_t     state_q, state_d;
  logic [3:0] ret_q, ret_d;      // one-hot {1000, 500, 100, 50}
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       fault_q, fault_d;
  logic [6:0] rem_q, rem_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;
  logic [6:0] coin_val;

  assign cnt_inc = cnt_q + 8'd1;

  // Value of the coin currently requested, in 50-won units
  always_comb begin
    coin_val = 7'd0;
    if (ret_q[3])      coin_val = 7'd20;
    else if (ret_q[2]) coin_val = 7'd10;
    else if (ret_q[1]) coin_val = 7'd2;
    else if (ret_q[0]) coin_val = 7'd1;
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fault_d = fault_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          rem_d   = Amount;
          busy_d  = 1'b1;
          state_d = SELECT;
        end
      end
      SELECT: begin
        cnt_d   = 8'd0;
        state_d = REQ;
        if (rem_q >= 7'd20)      ret_d = 4'b1000;
        else if (rem_q >= 7'd10) ret_d = 4'b0100;
        else if (rem_q >= 7'd2)  ret_d = 4'b0010;
        else if (rem_q >= 7'd1)  ret_d = 4'b0001;
        else                     state_d = FIN;
      end
      REQ: begin
        // Ack takes priority over a timeout landing on the same edge
        if (Ack) begin
          ret_d   = 4'b0000;
          rem_d   = (rem_q >= coin_val) ? rem_q - coin_val : 7'd0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO) begin
            ret_d   = 4'b0000;
            fault_d = 1'b1;
            state_d = FAULT;
          end
        end
      end
      RELEASE: begin
        if (!Ack) state_d = SELECT;
      end
      FIN: begin
        // First FIN cycle raises Done; the second drops Busy with it
        if (!done_q) begin
          done_d = 1'b1;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
        ret_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ret_q   <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rem_q   <= 7'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign {Return1000, Return500, Return100, Return50} = ret_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Fault     = fault_q;
  assign Remaining = rem_q;

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-return sequencer for the vending machine. On a refund request it takes the amount to return and pays it out greedily, largest coin first: 1000, 500, 100, then 50 won. It drives the Return1000/Return500/Return100/Return50 lines one coin at a time and waits for a level handshake from the coin hopper after each coin. It sits between the control unit, which supplies the refund amount from the datapath Sum, and the hopper outputs at the top level.

## Interface
- ACK_TIMEOUT, 255: cycles REQ may wait for Ack before declaring a fault; valid range 1..255, 8-bit counter.
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Start  in  1  refund request; sampled only in IDLE.
- Amount  in  7  refund value in 50-won units (1000=20, 500=10, 100=2, 50=1); max 127 (6350 won).
- Ack  in  1  hopper level acknowledge; high means the current coin was ejected.
- Return1000, Return500, Return100, Return50  out  1 each  one-hot coin request, registered.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when the refund completes.
- Fault  out  1  sticky hopper-timeout flag.
- Remaining  out  7  value not yet paid out, in 50-won units.

## Operation
**States:** IDLE, SELECT, REQ, RELEASE, FIN, FAULT.

- **IDLE**
  - Start=1: load Remaining<=Amount, go to SELECT.
  - Ack is ignored.
- **SELECT** picks the coin by comparing Remaining, in this priority:
  - Remaining>=20 → Return1000
  - Remaining>=10 → Return500
  - Remaining>=2 → Return100
  - Remaining>=1 → Return50
  - Remaining=0 → go to FIN, no coin.
  - When a coin is picked: set the matching Return line, clear the timeout counter, go to REQ.
- **REQ**
  - Hold the Return line.
  - Ack=1: clear all Return lines, subtract the coin value from Remaining (never underflows), go to RELEASE.
  - Otherwise increment the counter. When the counter reaches ACK_TIMEOUT: clear Return lines, set Fault, go to FAULT. Remaining is left unchanged.
- **RELEASE**
  - Wait for Ack=0, then go to SELECT.
  - This keeps one Ack level from being counted as two coins.
- **FIN**
  - Done=1 for this cycle only, then go to IDLE.
  - Remaining reads 0.
- **FAULT**
  - Terminal state; only RST leaves it.
  - Busy=1, all Return lines 0, Start ignored.
  - Remaining shows the unpaid amount.
- **Invariants**
  - At most one Return line is high at any time.
  - Return lines are high only in REQ.
- Start while Busy is ignored. Amount is sampled only on the accepting edge.
- RST at any time, including mid-coin, forces:
  - IDLE
  - all Return lines, Busy, Done and Fault to 0
  - Remaining=0, counter=0.
  No partial coin is credited.

## Timing
- All outputs are registered. Reset values of all outputs are 0.
- **Start accepted at edge k:** Busy=1 and Remaining=Amount after edge k; the Return line rises after edge k+1.
- **Ack high sampled at edge m:** the Return line falls and Remaining updates after edge m.
- **Next coin:** with Ack low sampled at edge n (RELEASE → SELECT), the next Return line rises after edge n+1.
- **Minimum per coin** with an ideal hopper (Ack high for exactly one cycle): 3 cycles (REQ, RELEASE, SELECT).
- **Amount=0:** Done pulses after edge k+2; Busy falls together with Done at edge k+3.
- **Fault:** asserted after ACK_TIMEOUT edges in REQ without Ack, counted from REQ entry.
- **Ack=1 in the same cycle the counter hits ACK_TIMEOUT:** Ack wins; no fault.

## Test plan
- **Amount=37, Ack one cycle after each request:** coin order 1000, 500, 100, 100, 100, 50. Remaining steps 37→17→7→5→3→1→0, then one Done pulse, then Busy=0.
- **Amount=127:** six Return1000, three Return100, one Return50, no Return500. Done once; Return lines never overlap.
- **Amount=0:** no Return pulse; Done two cycles after Start; Busy high exactly 3 cycles.
- **Ack never asserted, ACK_TIMEOUT=8, Amount=20:** Return1000 high 8 cycles then low. Fault=1, Remaining=20, state holds until RST; a later Start has no effect.
- **Ack held high 5 cycles:** exactly one coin is debited per request. A second Start mid-refund with Amount=99 does not change Remaining.
- **RST asserted while Return500 is high:** all outputs are 0 immediately (asynchronous). After release, Start with Amount=2 yields a single Return100 and Done.
